// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the triggered ADC capture block.
package adc_cap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_ARMED,
      ST_POST
   } state_t;

   localparam logic MODE_IMMEDIATE = 1'b0;
   localparam logic MODE_TRIGGERED = 1'b1;

endpackage

// File: rtl/adc_beat_packer.sv
// Packs RATIO input beats into one wide word, lane 0 in the LSBs.
module adc_beat_packer #(
   parameter int DWIDTH = 128,
   parameter int RATIO  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     beat_valid,
   input  logic [DWIDTH-1:0]        beat_data,
   output logic                     word_valid,
   output logic [DWIDTH*RATIO-1:0]  word_data
);

   localparam int            PW   = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [PW-1:0] LAST = PW'(RATIO - 1);

   logic [PW-1:0]            phase;
   logic [DWIDTH*RATIO-1:0]  lanes;
   logic [DWIDTH*RATIO-1:0]  lanes_next;

   // NOTE: the default assignment before the loop keeps this purely combinational (no latch).
   always_comb begin
      lanes_next = lanes;
      for (int i = 0; i < RATIO; i++) begin
         if (phase == PW'(i)) lanes_next[i*DWIDTH +: DWIDTH] = beat_data;
      end
   end

   // NOTE: state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase      <= '0;
         lanes      <= '0;
         word_valid <= 1'b0;
         word_data  <= '0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            phase <= '0;
         end else if (beat_valid) begin
            lanes <= lanes_next;
            if (phase == LAST) begin
               phase      <= '0;
               word_valid <= 1'b1;
               word_data  <= lanes_next;
            end else begin
               phase <= phase + PW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/adc_cap_trig.sv
// ADC stream capture into a BRAM ring, immediate or triggered with pre-trigger history.
module adc_cap_trig
   import adc_cap_pkg::*;
#(
   parameter int  DWIDTH_IN = 128,
   parameter int  RATIO     = 2,
   parameter int  MAX_XFER  = 2048,
   localparam int ADDR_BITS = $clog2(MAX_XFER)
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [DWIDTH_IN-1:0]           s_axis_tdata,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           capture_i,
   input  logic                           trig_i,
   input  logic                           mode_i,
   input  logic [ADDR_BITS-1:0]           pretrig_i,
   output logic                           done_o,
   output logic [ADDR_BITS-1:0]           trig_addr_o,
   output logic [DWIDTH_IN*RATIO-1:0]     bram_wdata,
   output logic [DWIDTH_IN*RATIO/8-1:0]   bram_we,
   output logic                           bram_en,
   input  logic [DWIDTH_IN*RATIO-1:0]     bram_rdata,
   output logic [31:0]                    bram_addr,
   output logic                           bram_clk,
   output logic                           bram_rst
);

   localparam int               WWIDTH   = DWIDTH_IN * RATIO;
   localparam int               WE_BITS  = WWIDTH / 8;
   localparam logic [ADDR_BITS:0] XFER_LEN = (ADDR_BITS+1)'(MAX_XFER);

   state_t                 state;
   state_t                 state_next;
   logic                   cap_d;
   logic                   trig_d;
   logic                   cap_rise;
   logic                   trig_rise;
   logic                   start;
   logic                   wr;
   logic [ADDR_BITS-1:0]   addr;
   logic [ADDR_BITS-1:0]   pretrig_r;
   logic [ADDR_BITS-1:0]   trig_addr;
   logic [ADDR_BITS:0]     cnt;
   logic [ADDR_BITS:0]     cnt_inc;
   logic [ADDR_BITS:0]     post_len;
   logic                   word_valid;
   logic [WWIDTH-1:0]      word_data;
   logic                   unused_rdata;

   assign unused_rdata = ^bram_rdata;

   assign cap_rise  = capture_i & ~cap_d;
   assign trig_rise = trig_i & ~trig_d;
   assign start     = (state == ST_IDLE) && cap_rise;
   assign wr        = word_valid && (state != ST_IDLE);
   assign cnt_inc   = cnt + (ADDR_BITS+1)'(1);
   assign post_len  = XFER_LEN - {1'b0, pretrig_r};

   adc_beat_packer #(
      .DWIDTH (DWIDTH_IN),
      .RATIO  (RATIO)
   ) u_packer (
      .clk        (aclk),
      .rst_n      (aresetn),
      .clear      (start),
      .beat_valid (s_axis_tvalid),
      .beat_data  (s_axis_tdata),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (cap_rise) begin
               if (mode_i == MODE_TRIGGERED && pretrig_i != '0) state_next = ST_FILL;
               else                                             state_next = ST_POST;
            end
         end
         ST_FILL:  if (wr && cnt_inc == {1'b0, pretrig_r}) state_next = ST_ARMED;
         ST_ARMED: if (trig_rise)                          state_next = ST_POST;
         ST_POST:  if (wr && cnt_inc == post_len)          state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // The count restarts at the trigger so POST counts only post-trigger words.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cap_d     <= 1'b0;
         trig_d    <= 1'b0;
         addr      <= '0;
         cnt       <= '0;
         pretrig_r <= '0;
         trig_addr <= '0;
      end else begin
         cap_d  <= capture_i;
         trig_d <= trig_i;
         if (start) begin
            addr      <= '0;
            cnt       <= '0;
            trig_addr <= '0;
            pretrig_r <= (mode_i == MODE_IMMEDIATE) ? '0 : pretrig_i;
         end else begin
            if (wr) addr <= addr + ADDR_BITS'(1);
            if (state == ST_ARMED && trig_rise) begin
               cnt       <= '0;
               trig_addr <= wr ? addr + ADDR_BITS'(1) : addr;
            end else if (wr) begin
               cnt <= cnt_inc;
            end
         end
      end
   end

   assign s_axis_tready = 1'b1;
   assign done_o        = (state == ST_IDLE);
   assign trig_addr_o   = trig_addr;
   assign bram_en       = wr;
   assign bram_we       = {WE_BITS{wr}};
   assign bram_wdata    = word_data;
   assign bram_addr     = 32'(addr);
   assign bram_clk      = aclk;
   assign bram_rst      = ~aresetn;

endmodule

// File: tb/tb_adc_cap_trig.sv
// Directed bench for adc_cap_trig: capture scenarios from a vector table plus reset/idle sequences.
module tb_adc_cap_trig;

   localparam int DW = 8;
   localparam int RT = 2;
   localparam int MX = 16;
   localparam int AB = 4;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [DW-1:0]     s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              capture_i;
   logic              trig_i;
   logic              mode_i;
   logic [AB-1:0]     pretrig_i;
   logic              done_o;
   logic [AB-1:0]     trig_addr_o;
   logic [DW*RT-1:0]  bram_wdata;
   logic [DW*RT/8-1:0] bram_we;
   logic              bram_en;
   logic [DW*RT-1:0]  bram_rdata;
   logic [31:0]       bram_addr;
   logic              bram_clk;
   logic              bram_rst;

   always #5 aclk = ~aclk;

   adc_cap_trig #(
      .DWIDTH_IN (DW),
      .RATIO     (RT),
      .MAX_XFER  (MX)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .capture_i     (capture_i),
      .trig_i        (trig_i),
      .mode_i        (mode_i),
      .pretrig_i     (pretrig_i),
      .done_o        (done_o),
      .trig_addr_o   (trig_addr_o),
      .bram_wdata    (bram_wdata),
      .bram_we       (bram_we),
      .bram_en       (bram_en),
      .bram_rdata    (bram_rdata),
      .bram_addr     (bram_addr),
      .bram_clk      (bram_clk),
      .bram_rst      (bram_rst)
   );

   typedef struct {
      string       name;
      logic        mode;
      logic [3:0]  pretrig;
      bit          gap;
      int          trig_a;
      int          trig_dly;
      int          trig_b;
      int          cap_a;
      int          exp_writes;
      int          exp_trig;
      int          exp_last;
   } vec_t;

   vec_t        vecs [9];
   int          n_pass  = 0;
   int          n_total = 0;
   logic [7:0]  beat;

   int          nwr;
   int          consec;
   int          we_bad;
   logic        prev_en;
   logic [3:0]  log_addr [64];
   logic [15:0] log_data [64];

   // Write monitor, sampled mid-cycle while the clock is low.
   always @(negedge aclk) begin
      if (bram_en) begin
         if (nwr < 64) begin
            log_addr[nwr] = bram_addr[3:0];
            log_data[nwr] = bram_wdata;
         end
         nwr = nwr + 1;
         if (prev_en) consec = consec + 1;
         if (bram_we != 2'b11 || bram_addr[31:4] != 28'd0) we_bad = we_bad + 1;
      end else if (bram_we != 2'b00) begin
         we_bad = we_bad + 1;
      end
      prev_en = bram_en;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else             n_pass++;
   endtask

   task automatic clear_log();
      nwr     = 0;
      consec  = 0;
      we_bad  = 0;
      prev_en = 1'b0;
   endtask

   task automatic drive_cycle(input logic valid, input logic trg, input logic cap);
      @(posedge aclk);
      #1;
      s_axis_tvalid = valid;
      s_axis_tdata  = beat;
      trig_i        = trg;
      capture_i     = cap;
      if (valid) beat = beat + 8'd1;
   endtask

   task automatic run_vector(input vec_t v);
      bit   busy_seen = 0;
      bit   done_seen = 0;
      bit   armed_a   = 0;
      bit   fired_a   = 0;
      bit   fired_b   = 0;
      bit   cap_done  = 0;
      bit   prev_trg  = 0;
      int   dly       = 0;
      int   last;
      logic valid, trg, cap;
      mode_i    = v.mode;
      pretrig_i = v.pretrig;
      clear_log();
      beat = 8'd0;
      drive_cycle(1'b0, 1'b0, 1'b1);
      for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
         valid = !(v.gap && (cyc % 3 == 2));
         trg   = 1'b0;
         cap   = 1'b0;
         if (v.trig_a >= 0 && !armed_a && nwr >= v.trig_a) begin
            armed_a = 1;
            dly     = v.trig_dly;
         end
         if (armed_a && !fired_a) begin
            if (dly == 0) begin
               trg     = 1'b1;
               fired_a = 1;
            end else begin
               dly--;
            end
         end else if (v.trig_b >= 0 && fired_a && !fired_b && !prev_trg && nwr >= v.trig_b) begin
            trg     = 1'b1;
            fired_b = 1;
         end
         if (v.cap_a >= 0 && !cap_done && nwr >= v.cap_a) begin
            cap      = 1'b1;
            cap_done = 1;
         end
         prev_trg = trg;
         drive_cycle(valid, trg, cap);
         @(negedge aclk);
         #1;
         if (!done_o)        busy_seen = 1;
         else if (busy_seen) done_seen = 1;
      end
      s_axis_tvalid = 1'b0;
      trig_i        = 1'b0;
      capture_i     = 1'b0;
      check({v.name, "_done"}, 32'(done_seen), 32'd1);
      check({v.name, "_writes"}, 32'(nwr), 32'(v.exp_writes));
      check({v.name, "_trig_addr"}, 32'(trig_addr_o), 32'(v.exp_trig));
      check({v.name, "_consec"}, 32'(consec), 32'd0);
      check({v.name, "_we"}, 32'(we_bad), 32'd0);
      last = (nwr > 0 && nwr <= 64) ? nwr - 1 : 0;
      check({v.name, "_last_addr"}, 32'(log_addr[last]), 32'(v.exp_last));
      for (int k = 0; k < nwr && k < 64; k++) begin
         check($sformatf("%s_addr%0d", v.name, k), 32'(log_addr[k]), 32'(k % MX));
         check($sformatf("%s_data%0d", v.name, k), 32'(log_data[k]),
               32'({8'((2 * k) + 1), 8'(2 * k)}));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit = 0;

      //            name        mode  pre  gap trig_a dly trig_b cap_a writes trig last
      vecs[0] = '{"imm",       1'b0, 4'd0,  0,  -1,   0,  -1,    -1,   16,    0,   15};
      vecs[1] = '{"imm_gap",   1'b0, 4'd0,  1,  -1,   0,  -1,    -1,   16,    0,   15};
      vecs[2] = '{"imm_pre4",  1'b0, 4'd4,  0,  -1,   0,  -1,    -1,   16,    0,   15};
      vecs[3] = '{"trg10",     1'b1, 4'd4,  0,  10,   0,  -1,    -1,   22,   10,    5};
      vecs[4] = '{"trg_fill",  1'b1, 4'd4,  0,   2,   0,   7,    -1,   19,    7,    2};
      vecs[5] = '{"trg_pre0",  1'b1, 4'd0,  0,  -1,   0,  -1,    -1,   16,    0,   15};
      vecs[6] = '{"cap_post",  1'b1, 4'd4,  0,   6,   0,  -1,     8,   18,    6,    1};
      vecs[7] = '{"trg_pre15", 1'b1, 4'd15, 0,  20,   0,  -1,    -1,   21,    4,    4};
      vecs[8] = '{"trg_edge",  1'b1, 4'd4,  0,   3,   1,   8,    -1,   20,    8,    3};

      aresetn       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      capture_i     = 1'b0;
      trig_i        = 1'b0;
      mode_i        = 1'b0;
      pretrig_i     = '0;
      bram_rdata    = '0;
      beat          = 8'd0;
      clear_log();

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_done", 32'(done_o), 32'd1);
      check("rst_en", 32'(bram_en), 32'd0);
      check("rst_we", 32'(bram_we), 32'd0);
      check("rst_addr", bram_addr, 32'd0);
      check("rst_trig_addr", 32'(trig_addr_o), 32'd0);
      check("rst_wdata", 32'(bram_wdata), 32'd0);
      check("rst_bram_rst", 32'(bram_rst), 32'd1);
      check("rst_tready", 32'(s_axis_tready), 32'd1);
      check("rst_bram_clk", 32'(bram_clk), 32'(aclk));
      aresetn = 1'b1;
      #1;
      check("rel_bram_rst", 32'(bram_rst), 32'd0);

      foreach (vecs[i]) run_vector(vecs[i]);

      // Reset asserted in the middle of a write during POST.
      mode_i    = 1'b0;
      pretrig_i = '0;
      clear_log();
      beat = 8'd0;
      drive_cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 100 && !hit; i++) begin
         drive_cycle(1'b1, 1'b0, 1'b0);
         @(negedge aclk);
         #1;
         if (bram_en && nwr >= 5) hit = 1;
      end
      check("mid_reach_write", 32'(hit), 32'd1);
      aresetn = 1'b0;
      #1;
      check("mid_rst_en", 32'(bram_en), 32'd0);
      check("mid_rst_we", 32'(bram_we), 32'd0);
      check("mid_rst_done", 32'(done_o), 32'd1);
      check("mid_rst_addr", bram_addr, 32'd0);
      check("mid_rst_bram_rst", 32'(bram_rst), 32'd1);
      s_axis_tvalid = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      run_vector(vecs[0]);

      // Trigger and completed words while idle must not write or move trig_addr_o.
      run_vector(vecs[3]);
      clear_log();
      drive_cycle(1'b1, 1'b1, 1'b0);
      repeat (5) drive_cycle(1'b1, 1'b0, 1'b0);
      @(negedge aclk);
      #1;
      check("idle_trig_writes", 32'(nwr), 32'd0);
      check("idle_trig_done", 32'(done_o), 32'd1);
      check("idle_trig_addr", 32'(trig_addr_o), 32'd10);
      s_axis_tvalid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/adc_cap_trig.md
ADC_CAP_TRIG -- requirements
Module: adc_cap_trig

Interface
REQ-001 SHALL have parameter DWIDTH_IN, default 128, meaning input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 2, meaning input beats packed per BRAM word; legal values are 1, 2, 4 and 8.
REQ-003 SHALL have parameter MAX_XFER, default 2048, meaning BRAM depth in words; it is a power of 2. ADDR_BITS = clog2(MAX_XFER).
REQ-004 SHALL have port aclk, input, 1 bit: the single clock.
REQ-005 SHALL have port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports s_axis_tdata (input, DWIDTH_IN), s_axis_tvalid (input, 1) and s_axis_tready (output, 1): the ADC stream.
REQ-007 SHALL have port capture_i, input, 1 bit: arm request, acted on at its rising edge.
REQ-008 SHALL have port trig_i, input, 1 bit: trigger, acted on at its rising edge.
REQ-009 SHALL have port mode_i, input, 1 bit: 0 = immediate capture, 1 = triggered capture with pre-trigger.
REQ-010 SHALL have port pretrig_i, input, ADDR_BITS: number of pre-trigger words.
REQ-011 SHALL have port done_o, output, 1 bit: high when the block is idle.
REQ-012 SHALL have port trig_addr_o, output, ADDR_BITS: word address of the first post-trigger word.
REQ-013 SHALL have BRAM master ports bram_wdata (output, DWIDTH_IN*RATIO), bram_we (output, DWIDTH_IN*RATIO/8), bram_en (output, 1), bram_rdata (input, DWIDTH_IN*RATIO, unused), bram_addr (output, 32, word address zero-extended), bram_clk (output, 1) and bram_rst (output, 1).

Function
REQ-014 s_axis_tready SHALL be constant 1; a beat is accepted only when s_axis_tvalid=1, unlike the previous capture block, which ignored tvalid.
REQ-015 Packer: accepted beats SHALL fill lanes 0..RATIO-1 in order, with lane 0 in the LSBs; a word is complete on the beat that fills lane RATIO-1.
REQ-016 The beat phase SHALL reset to lane 0 on every capture start; a partially filled word is discarded.
REQ-017 Write latency: bram_en, all bram_we bits, bram_wdata and bram_addr SHALL assert for exactly one cycle, one cycle after a word completes, while the state is FILL, ARMED or POST; otherwise bram_en=0 and bram_we=0.
REQ-018 bram_addr SHALL start at 0 on capture start, increment by 1 per write, and wrap modulo MAX_XFER.
REQ-019 States SHALL be IDLE, FILL, ARMED and POST; done_o=1 only in IDLE.
REQ-020 IDLE + capture_i rising edge SHALL sample mode_i and pretrig_i, reset the address and counters, and go to POST if mode=0 or pretrig=0, else to FILL.
REQ-021 FILL SHALL go to ARMED on the write that brings the write count to pretrig.
REQ-022 ARMED SHALL keep writing, with the address wrapping; a trig_i rising edge SHALL move to POST and latch trig_addr_o to the address of the next write.
REQ-023 POST SHALL write (MAX_XFER - pretrig) words, using pretrig=0 in immediate mode, then go to IDLE in the cycle after the last write.
REQ-024 In immediate mode, trig_addr_o SHALL be 0.
REQ-025 A trigger in IDLE, FILL or POST SHALL be ignored; capture_i edges outside IDLE SHALL be ignored.
REQ-026 A trigger edge coinciding with the write that completes FILL SHALL be ignored; the block enters ARMED only.
REQ-027 bram_clk SHALL equal aclk and bram_rst SHALL equal NOT aresetn.

Reset
REQ-028 Asserting aresetn low at any time, including mid-capture, SHALL immediately force IDLE, done_o=1, bram_en=0, bram_we=0, address 0, trig_addr_o=0, all edge detectors 0 and the packer phase 0.
REQ-029 bram_wdata and the packer data registers SHALL reset to 0.

Structure
REQ-030 A package adc_cap_pkg SHALL hold the state enumeration and the mode constants (MODE_IMMEDIATE=0, MODE_TRIGGERED=1).
REQ-031 The packer SHALL be a sub-module adc_beat_packer, with ports clock, reset, clear, beat valid and data in, and word valid and data out.
REQ-032 All logic SHALL be in the aclk domain; the block SHALL contain no clock-domain crossings.

Verification (RATIO=2, MAX_XFER=16, DWIDTH_IN=8)
REQ-033 Stimulus: mode=0, capture edge, 32 beats 0x00..0x1F with tvalid=1. Required: 16 writes at addresses 0..15, word 0 = 0x0100, word 15 = 0x1F1E, done_o returns to 1, trig_addr_o=0.
REQ-034 Stimulus: as REQ-033 with tvalid low on every third cycle. Required: identical BRAM contents and addresses, writes never on consecutive-beat gaps.
REQ-035 Stimulus: mode=1, pretrig=4, trigger after 10 writes. Required: trig_addr_o=10 (mod 16), 12 post writes ending at address 5, total writes 22.
REQ-036 Stimulus: mode=1, pretrig=4, trigger pulse during FILL, then second trigger in ARMED. Required: first trigger ignored, trig_addr_o from second.
REQ-037 Stimulus: aresetn low during POST. Required: bram_en=0 in same cycle, done_o=1; a new capture after release restarts at address 0.
REQ-038 Stimulus: capture pulses during POST. Required: ignored, exactly MAX_XFER-pretrig post writes.
